// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity codes,
// FSM state encoding and the parity helper.
package uart_tx_fifo_param_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Width of the per-frame bit counter; covers up to 9 data bits.
  localparam int BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity over a zero-extended word; extra zero bits do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (mode == PARITY_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous word FIFO with first-word fall-through read and level output.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic [W-1:0]     o_data,
  output logic [LVL_W-1:0] o_level,
  output logic             o_full,
  output logic             o_empty
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Storage write; no reset needed since the level gates every read.
  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and level; pointers wrap naturally as DEPTH is a power of 2.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with input word FIFO and CTS_N gating of
// frame starts. TXD is a register fed from the FSM state, so the line lags
// the state by one cycle and every bit still lasts exactly CLKS_PER_BIT.
module uart_tx_fifo_param
  import uart_tx_fifo_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = 26,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1),
  localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 DATA_VALID,
  output logic                 DATA_READY,
  input  logic                 CTS_N,
  output logic                 TXD,
  output logic                 BUSY,
  output logic [LVL_W-1:0]     FIFO_LEVEL
);

  tx_state_e              r_state;
  tx_state_e              w_state_nxt;
  logic [CNT_W-1:0]       r_baud;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_txd;
  logic                   w_tick;
  logic                   w_pop;
  logic                   w_can_start;
  logic                   w_last_data;
  logic                   w_last_stop;
  logic [DATA_BITS-1:0]   w_fifo_dout;
  logic [LVL_W-1:0]       w_fifo_level;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  uart_sync_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (DATA_VALID),
    .i_data  (DATA),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_level (w_fifo_level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_tick      = (r_baud == CNT_W'(CLKS_PER_BIT - 1));
  assign w_can_start = ~w_fifo_empty & ~CTS_N;
  assign w_last_data = (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == BIT_CNT_W'(STOP_BITS - 1));

  assign DATA_READY = ~w_fifo_full;
  assign FIFO_LEVEL = w_fifo_level;
  assign BUSY       = (r_state != ST_IDLE) | ~w_fifo_empty;
  assign TXD        = r_txd;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and pop decision; the final stop tick reuses the idle start check.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick && w_last_data)
          w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_tick) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick && w_last_stop) begin
          if (w_can_start) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Baud counter, bit counter, shift register and latched parity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else if (w_pop) begin
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= w_fifo_dout;
      r_par     <= parity_bit(9'(w_fifo_dout), PARITY);
    end else if (r_state != ST_IDLE) begin
      r_baud <= w_tick ? '0 : r_baud + CNT_W'(1);
      if (w_tick) begin
        case (r_state)
          ST_DATA: begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + BIT_CNT_W'(1);
          end
          ST_STOP: r_bit_cnt <= w_last_stop ? '0 : r_bit_cnt + BIT_CNT_W'(1);
          default: r_bit_cnt <= '0;
        endcase
      end
    end
  end

  // Serial line register: driven from the current state, idle/stop high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_txd <= 1'b1;
    end else begin
      case (r_state)
        ST_START:  r_txd <= 1'b0;
        ST_DATA:   r_txd <= r_shift[0];
        ST_PARITY: r_txd <= r_par;
        default:   r_txd <= 1'b1;
      endcase
    end
  end

endmodule
